// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and clock-phase modes,
// used by the sck generator, the shifter and the controller.
package spi_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } spi_state_e;

  // cpha = 0: data captured on the leading sck edge, driven on the trailing one
  localparam logic CPHA_LEAD  = 1'b0;
  // cpha = 1: data driven on the leading sck edge, captured on the trailing one
  localparam logic CPHA_TRAIL = 1'b1;

  // True when an edge of the given type is the capture edge for this mode
  function automatic logic is_sample_edge(input logic leading, input logic cpha);
    return (cpha == CPHA_LEAD) ? leading : ~leading;
  endfunction

endpackage

// File: rtl/spi_sck_gen_if.sv
// Frame request / sck strobe bundle between an SPI controller and the sck generator.
interface spi_sck_gen_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 5
) ();

  logic             start;
  logic             abort;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] nbits;
  logic             cpol;
  logic             cpha;
  logic             sck;
  logic             busy;
  logic             sample;
  logic             shift;
  logic             done;

  modport master (
    output start, abort, div, nbits, cpol, cpha,
    input  sck, busy, sample, shift, done
  );

  modport slave (
    input  start, abort, div, nbits, cpol, cpha,
    output sck, busy, sample, shift, done
  );

endinterface

// File: rtl/spi_div_cnt.sv
// Half-period counter: counts 0..div while enabled and flags the wrap cycle,
// which is the cycle on which the next sck edge is generated.
module spi_div_cnt #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt_r;

  assign wrap = en && (cnt_r == div);

  // Count up to div and fold back to zero; clr holds the count at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (en) begin
      if (cnt_r == div) begin
        cnt_r <= {DIV_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/spi_sck_gen.sv
// SPI serial clock generator: produces sck for one frame of nbits bits and the
// sample/shift/done strobes that pace the data shifter. All outputs registered.
module spi_sck_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_sck_gen_if.slave bus
);

  import spi_pkg::*;

  spi_state_e       state_r;
  logic [DIV_W-1:0] div_l_r;
  logic [CNT_W-1:0] nbits_l_r;
  logic             cpol_l_r;
  logic             cpha_l_r;
  logic [CNT_W:0]   edge_cnt_r;
  logic             sck_r;
  logic             busy_r;
  logic             sample_r;
  logic             shift_r;
  logic             done_r;

  logic             wrap_s;
  logic             cnt_en_s;
  logic             cnt_clr_s;
  logic             start_ok_s;
  logic [CNT_W:0]   edge_nxt_s;
  logic             lead_s;
  logic             final_s;
  logic             samp_edge_s;
  logic             shift_edge_s;

  // Edge classification for the edge (if any) generated this cycle
  always_comb begin
    cnt_en_s     = (state_r == ST_RUN);
    cnt_clr_s    = (state_r == ST_IDLE);
    start_ok_s   = bus.start && (bus.nbits != {CNT_W{1'b0}});
    edge_nxt_s   = edge_cnt_r + {{CNT_W{1'b0}}, 1'b1};
    // even number of edges already produced -> the coming edge is a leading one
    lead_s       = ~edge_cnt_r[0];
    final_s      = (edge_nxt_s == {nbits_l_r, 1'b0});
    samp_edge_s  = is_sample_edge(lead_s, cpha_l_r);
    // in cpha=0 the last trailing edge would shift out a bit past the frame
    shift_edge_s = ~samp_edge_s && ~((cpha_l_r == CPHA_LEAD) && final_s);
  end

  spi_div_cnt #(.DIV_W(DIV_W)) u_div_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en_s),
    .clr   (cnt_clr_s),
    .div   (div_l_r),
    .wrap  (wrap_s)
  );

  // Frame FSM with registered sck and strobes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      div_l_r    <= {DIV_W{1'b0}};
      nbits_l_r  <= {CNT_W{1'b0}};
      cpol_l_r   <= 1'b0;
      cpha_l_r   <= 1'b0;
      edge_cnt_r <= {(CNT_W+1){1'b0}};
      sck_r      <= 1'b0;
      busy_r     <= 1'b0;
      sample_r   <= 1'b0;
      shift_r    <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      sample_r <= 1'b0;
      shift_r  <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sck_r      <= bus.cpol;
          edge_cnt_r <= {(CNT_W+1){1'b0}};
          if (start_ok_s) begin
            div_l_r   <= bus.div;
            nbits_l_r <= bus.nbits;
            cpol_l_r  <= bus.cpol;
            cpha_l_r  <= bus.cpha;
            state_r   <= ST_RUN;
            busy_r    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            // abort wins over any edge due this cycle, including the last one
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            sck_r      <= cpol_l_r;
            edge_cnt_r <= {(CNT_W+1){1'b0}};
          end else if (wrap_s) begin
            sck_r      <= ~sck_r;
            sample_r   <= samp_edge_s;
            shift_r    <= shift_edge_s;
            edge_cnt_r <= edge_nxt_s;
            if (final_s) begin
              done_r  <= 1'b1;
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          sck_r   <= cpol_l_r;
        end
      endcase
    end
  end

  assign bus.sck    = sck_r;
  assign bus.busy   = busy_r;
  assign bus.sample = sample_r;
  assign bus.shift  = shift_r;
  assign bus.done   = done_r;

endmodule

// File: tb/tb_spi_sck_gen.sv
// Bench for spi_sck_gen: frame-level reference model checked every cycle,
// directed frames with hand-computed expectations, then randomized traffic.
module tb_spi_sck_gen;

  logic clk = 1'b0;
  logic rst_n;

  spi_sck_gen_if #(.DIV_W(8), .CNT_W(5)) bus ();

  spi_sck_gen #(.DIV_W(8), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // reference model state
  bit m_valid = 0;
  bit m_run   = 0;
  int m_s, m_div, m_n, m_pol, m_pha;
  bit e_sck, e_busy, e_sample, e_shift, e_done;

  // DUT event monitor
  bit prev_sck = 0;
  int mon_tog, mon_first, mon_samp, mon_samp_rise, mon_shift, mon_shift_fall;
  int mon_done, mon_done_cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: for a frame accepted at cycle T, the output cycle T+1+s shows
  // edge j = s/(div+1) whenever s is a multiple of div+1.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      m_valid  = 1;
      e_sample = 0;
      e_shift  = 0;
      e_done   = 0;
      if (!rst_n) begin
        m_run  = 0;
        e_sck  = 0;
        e_busy = 0;
      end else if (!m_run) begin
        e_sck  = bus.cpol;
        e_busy = 0;
        if (bus.start && bus.nbits != 0) begin
          m_div = int'(bus.div);
          m_n   = int'(bus.nbits);
          m_pol = int'(bus.cpol);
          m_pha = int'(bus.cpha);
          m_run = 1;
          m_s   = 0;
          e_busy = 1;
        end
      end else if (bus.abort) begin
        m_run  = 0;
        e_sck  = m_pol[0];
        e_busy = 0;
      end else begin
        int per, j;
        bit lead, smp;
        m_s++;
        per    = m_div + 1;
        j      = m_s / per;
        e_sck  = m_pol[0] ^ j[0];
        e_busy = 1;
        if (m_s % per == 0) begin
          lead     = (j % 2) == 1;
          smp      = (m_pha == 1) ? !lead : lead;
          e_sample = smp;
          e_shift  = !smp && !(m_pha == 0 && j == 2 * m_n);
          if (j == 2 * m_n) begin
            e_done = 1;
            m_run  = 0;
            e_busy = 0;
          end
        end
      end
    end
  end

  // Compare against the model and collect events, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("sck",    int'(bus.sck),    int'(e_sck));
      chk("busy",   int'(bus.busy),   int'(e_busy));
      chk("sample", int'(bus.sample), int'(e_sample));
      chk("shift",  int'(bus.shift),  int'(e_shift));
      chk("done",   int'(bus.done),   int'(e_done));
    end
    if (bus.sck != prev_sck) begin
      mon_tog++;
      if (mon_tog == 1) mon_first = cyc;
    end
    if (bus.sample) begin
      mon_samp++;
      if (bus.sck && !prev_sck) mon_samp_rise++;
    end
    if (bus.shift) begin
      mon_shift++;
      if (!bus.sck && prev_sck) mon_shift_fall++;
    end
    if (bus.done) begin
      mon_done++;
      mon_done_cyc = cyc;
    end
    prev_sck = bus.sck;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_tog = 0; mon_first = 0; mon_samp = 0; mon_samp_rise = 0;
    mon_shift = 0; mon_shift_fall = 0; mon_done = 0; mon_done_cyc = 0;
  endtask

  task automatic start_frame(input int d, input int n, input bit pol, input bit pha, output int t);
    bus.div   = 8'(d);
    bus.nbits = 5'(n);
    bus.cpol  = pol;
    bus.cpha  = pha;
    bus.start = 1'b1;
    t = cyc;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (mon_done == 0 && n < budget) begin
      step();
      n++;
    end
    if (mon_done == 0) chk({name, "_timeout"}, 0, 1);
    step();
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.div = 8'd0;
    bus.nbits = 5'd0; bus.cpol = 1'b1; bus.cpha = 1'b0;
    step(); step(); step();
    chk("rst_sck", int'(bus.sck), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_strobes", int'({bus.sample, bus.shift, bus.done}), 0);
    rst_n = 1'b1;
    bus.cpol = 1'b0;
    step(); step(); step();

    // div=0, nbits=8, mode 0
    mon_clear();
    start_frame(0, 8, 1'b0, 1'b0, t);
    wait_done(100, "m0");
    chk("m0_toggles", mon_tog, 16);
    chk("m0_first_edge", mon_first - t, 2);
    chk("m0_samples_rise", mon_samp_rise, 8);
    chk("m0_samples", mon_samp, 8);
    chk("m0_shifts_fall", mon_shift_fall, 7);
    chk("m0_shifts", mon_shift, 7);
    chk("m0_done_cycle", mon_done_cyc - t, 17);
    chk("m0_sck_end", int'(bus.sck), 0);

    // div=3, nbits=4, mode 3
    bus.cpol = 1'b1;
    step(); step();
    mon_clear();
    start_frame(3, 4, 1'b1, 1'b1, t);
    wait_done(100, "m3");
    chk("m3_first_edge", mon_first - t, 5);
    chk("m3_toggles", mon_tog, 8);
    chk("m3_shifts", mon_shift, 4);
    chk("m3_samples", mon_samp, 4);
    chk("m3_sck_end", int'(bus.sck), 1);

    // abort on the cycle producing the 5th edge
    bus.cpol = 1'b0;
    step(); step();
    mon_clear();
    start_frame(2, 8, 1'b0, 1'b0, t);
    while (cyc < t + 15) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("ab_busy", int'(bus.busy), 0);
    chk("ab_sck", int'(bus.sck), 0);
    repeat (20) step();
    chk("ab_done", mon_done, 0);
    chk("ab_toggles", mon_tog, 4);

    // nbits=0 start ignored; second start during a frame ignored
    mon_clear();
    start_frame(1, 0, 1'b0, 1'b0, t);
    step(); step(); step();
    chk("nb0_busy", int'(bus.busy), 0);
    chk("nb0_toggles", mon_tog, 0);
    start_frame(0, 2, 1'b0, 1'b0, t);
    step();
    bus.nbits = 5'd5; bus.div = 8'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(50, "dbl");
    repeat (10) step();
    chk("dbl_frames", mon_done, 1);
    chk("dbl_toggles", mon_tog, 4);

    // reset mid-frame then a clean frame
    bus.cpol = 1'b1;
    step(); step();
    start_frame(1, 3, 1'b1, 1'b0, t);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    chk("mrst_outs", int'({bus.sck, bus.busy, bus.sample, bus.shift, bus.done}), 0);
    rst_n = 1'b1;
    step(); step();
    mon_clear();
    start_frame(1, 3, 1'b1, 1'b0, t);
    wait_done(60, "mrst");
    chk("mrst_toggles", mon_tog, 6);
    chk("mrst_done", mon_done, 1);
    chk("mrst_sck_end", int'(bus.sck), 1);

    // cpol follows in idle with a one-cycle lag
    bus.cpol = 1'b0;
    chk("cpol_lag", int'(bus.sck), 1);
    step();
    chk("cpol_follow", int'(bus.sck), 0);

    // div changed mid-frame does not alter the period
    mon_clear();
    start_frame(1, 2, 1'b0, 1'b0, t);
    bus.div = 8'd5;
    wait_done(60, "divchg");
    chk("divchg_done_cycle", mon_done_cyc - t, 9);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom % 400) != 0;
      bus.start = ($urandom % 6) == 0;
      bus.nbits = 5'($urandom_range(0, 10));
      bus.div   = 8'($urandom_range(0, 4));
      if ($urandom % 10 == 0) bus.cpol = ~bus.cpol;
      bus.cpha  = 1'($urandom % 2);
      bus.abort = ($urandom % 70) == 0;
      step();
    end
    rst_n = 1'b1; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
